// File: rtl/exec_stage_mdu.sv
// Execute stage: single-cycle ALU/branch unit plus an iterative
// radix-2 multiply/divide unit behind valid/ready handshakes.
module exec_stage_mdu #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [3:0]            in_alu_op,
    input  logic [XLEN-1:0]       in_rs1,
    input  logic [XLEN-1:0]       in_rs2,
    input  logic [XLEN-1:0]       in_imm,
    input  logic                  in_use_imm,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    input  logic                  in_branch,
    input  logic                  in_reg_write,
    input  logic [REG_ADDR_W-1:0] in_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_result,
    output logic [XLEN-1:0]       out_store_data,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  out_branch_taken,
    output logic [XLEN-1:0]       out_branch_target,
    output logic                  busy
);
    localparam int SW = $clog2(XLEN);
    localparam int CW = SW + 1;

    typedef enum logic {IDLE, BUSY} state_t;
    state_t r_state, w_state_n;

    logic [CW-1:0]         r_cnt;
    logic [XLEN-1:0]       r_hi, r_lo, r_opd, r_sd;
    logic                  r_div, r_sel_hi, r_rw;
    logic [REG_ADDR_W-1:0] r_rd;

    logic [XLEN-1:0] w_b, w_alu, w_target;
    logic [SW-1:0]   w_sh;
    logic            w_taken, w_mc, w_accept, w_done;

    assign w_b  = in_use_imm ? in_imm : in_rs2;
    assign w_sh = w_b[SW-1:0];

    // MDU opcodes yield 0 on the single-cycle path (branch/memory forms only)
    always_comb begin
        w_alu = '0;
        case (in_alu_op)
            4'h0:    w_alu = in_rs1 + w_b;
            4'h1:    w_alu = in_rs1 - w_b;
            4'h2:    w_alu = in_rs1 << w_sh;
            4'h3:    w_alu = XLEN'($signed(in_rs1) < $signed(w_b));
            4'h4:    w_alu = XLEN'(in_rs1 < w_b);
            4'h5:    w_alu = in_rs1 ^ w_b;
            4'h6:    w_alu = in_rs1 >> w_sh;
            4'h7:    w_alu = $signed(in_rs1) >>> w_sh;
            4'h8:    w_alu = in_rs1 | w_b;
            4'h9:    w_alu = in_rs1 & w_b;
            default: w_alu = '0;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        if (in_branch) begin
            case (in_alu_op[2:0])
                3'b000:  w_taken = (in_rs1 == in_rs2);
                3'b001:  w_taken = (in_rs1 != in_rs2);
                3'b100:  w_taken = ($signed(in_rs1) < $signed(in_rs2));
                3'b101:  w_taken = ($signed(in_rs1) >= $signed(in_rs2));
                3'b110:  w_taken = (in_rs1 < in_rs2);
                3'b111:  w_taken = (in_rs1 >= in_rs2);
                default: w_taken = 1'b0;
            endcase
        end
    end

    assign w_target = w_taken ? (in_pc + in_imm) : '0;

    assign w_mc = (in_alu_op >= 4'hA) && (in_alu_op <= 4'hD)
                  && !in_branch && !in_mem_read && !in_mem_write;

    assign in_ready = (r_state == IDLE) && !flush && (!out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_done   = (r_state == BUSY) && (r_cnt == CW'(1));
    assign busy     = (r_state == BUSY);

    // Multiply: {hi,lo} is the running product, lo starts as the multiplier
    logic [XLEN:0]   w_msum;
    logic [XLEN-1:0] w_mhi, w_mlo;
    assign w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);
    assign w_mhi  = w_msum[XLEN:1];
    assign w_mlo  = {w_msum[0], r_lo[XLEN-1:1]};

    // Divide: hi is the partial remainder, lo shifts dividend out/quotient in
    logic [XLEN:0]   w_shift, w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_dhi, w_dlo, w_nhi, w_nlo, w_mdu_res;
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_opd};
    assign w_ge    = (w_shift >= {1'b0, r_opd});
    assign w_dhi   = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign w_dlo   = {r_lo[XLEN-2:0], w_ge};

    assign w_nhi     = r_div ? w_dhi : w_mhi;
    assign w_nlo     = r_div ? w_dlo : w_mlo;
    assign w_mdu_res = r_sel_hi ? w_nhi : w_nlo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        if (flush) begin
            w_state_n = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_accept && w_mc) w_state_n = BUSY;
                BUSY:    if (w_done) w_state_n = IDLE;
                default: w_state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt             <= '0;
            r_hi              <= '0;
            r_lo              <= '0;
            r_opd             <= '0;
            r_sd              <= '0;
            r_div             <= 1'b0;
            r_sel_hi          <= 1'b0;
            r_rw              <= 1'b0;
            r_rd              <= '0;
            out_valid         <= 1'b0;
            out_result        <= '0;
            out_store_data    <= '0;
            out_rd            <= '0;
            out_reg_write     <= 1'b0;
            out_mem_read      <= 1'b0;
            out_mem_write     <= 1'b0;
            out_branch_taken  <= 1'b0;
            out_branch_target <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            r_cnt     <= '0;
        end else begin
            if (w_accept && w_mc) begin
                r_cnt    <= CW'(XLEN);
                r_hi     <= '0;
                r_lo     <= in_alu_op[2] ? in_rs1 : w_b;
                r_opd    <= in_alu_op[2] ? w_b : in_rs1;
                r_div    <= in_alu_op[2];
                r_sel_hi <= in_alu_op[0];
                r_sd     <= in_rs2;
                r_rd     <= in_rd;
                r_rw     <= in_reg_write;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt - CW'(1);
                r_hi  <= w_nhi;
                r_lo  <= w_nlo;
            end

            if (w_accept && !w_mc) begin
                out_valid         <= 1'b1;
                out_result        <= w_alu;
                out_store_data    <= in_rs2;
                out_rd            <= in_rd;
                out_reg_write     <= in_reg_write;
                out_mem_read      <= in_mem_read;
                out_mem_write     <= in_mem_write;
                out_branch_taken  <= w_taken;
                out_branch_target <= w_target;
            end else if (w_done) begin
                out_valid         <= 1'b1;
                out_result        <= w_mdu_res;
                out_store_data    <= r_sd;
                out_rd            <= r_rd;
                out_reg_write     <= r_rw;
                out_mem_read      <= 1'b0;
                out_mem_write     <= 1'b0;
                out_branch_taken  <= 1'b0;
                out_branch_target <= '0;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_exec_stage_mdu.sv
// Directed bench for exec_stage_mdu with a result scoreboard.
module tb_exec_stage_mdu;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
    logic [3:0]  in_alu_op, in_rd, out_rd;
    logic        in_use_imm, in_mem_read, in_mem_write, in_branch, in_reg_write;
    logic        out_valid, out_ready, out_reg_write, out_mem_read, out_mem_write;
    logic        out_branch_taken, busy;
    logic [31:0] out_result, out_store_data, out_branch_target;

    exec_stage_mdu #(.XLEN(32), .REG_ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_alu_op(in_alu_op), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_use_imm(in_use_imm),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_branch(in_branch), .in_reg_write(in_reg_write), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_store_data(out_store_data),
        .out_rd(out_rd), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_branch_taken(out_branch_taken),
        .out_branch_target(out_branch_target), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  rd;
        logic        rw;
        logic        tk;
        logic [31:0] tgt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(logic [31:0] res, logic [3:0] rd, logic rw,
                                logic tk, logic [31:0] tgt);
        exp_t e;
        e.res = res; e.rd = rd; e.rw = rw; e.tk = tk; e.tgt = tgt;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: every transferred bundle must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t g, e;
            logic hv;
            g  = {out_result, out_rd, out_reg_write, out_branch_taken, out_branch_target};
            hv = (q.size() != 0);
            total++;
            assert (hv) else begin
                bad++;
                $error("FAIL sb_unexpected got=%h exp=none", g);
            end
            if (hv) begin
                e = q.pop_front();
                total++;
                assert (g === e) else begin
                    bad++;
                    $error("FAIL sb_bundle got=%h exp=%h", g, e);
                end
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic ui, input logic br,
                        input logic [3:0] rd, input logic rw, input logic push,
                        input exp_t e);
        int n;
        in_alu_op = op; in_rs1 = a; in_rs2 = b; in_imm = imm;
        in_use_imm = ui; in_branch = br; in_rd = rd; in_reg_write = rw;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("accept_timeout", 64'(n < 200), 64'd1);
        if (push) q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic rdy_bad, seen;
        int c0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_pc = '0; in_alu_op = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        in_use_imm = 1'b0; in_mem_read = 1'b0; in_mem_write = 1'b0;
        in_branch = 1'b0; in_reg_write = 1'b0; in_rd = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(out_result), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        send(4'h0, 32'd5, 32'd0, 32'd7, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1,
             mk(32'd12, 4'd3, 1'b1, 1'b0, 32'd0));
        @(negedge clk);
        chk("add_latency", 64'(out_valid), 64'd1);
        chk("add_result", 64'(out_result), 64'd12);
        drain();

        send(4'h1, 32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1,
             mk(32'hFFFF_FFFE, 4'd1, 1'b1, 1'b0, 32'd0));
        send(4'h7, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1,
             mk(32'hF800_0000, 4'd2, 1'b1, 1'b0, 32'd0));
        send(4'h3, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 4'd4, 1'b1, 1'b1,
             mk(32'd1, 4'd4, 1'b1, 1'b0, 32'd0));
        drain();

        send(4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b1,
             mk(32'd1, 4'd5, 1'b1, 1'b0, 32'd0));
        n = 0; rdy_bad = 1'b0;
        @(negedge clk);
        while (busy && n < 100) begin
            if (in_ready) rdy_bad = 1'b1;
            n++;
            @(negedge clk);
        end
        chk("mul_busy_cycles", 64'(n), 64'd32);
        chk("mul_ready_low", 64'(rdy_bad), 64'd0);
        chk("mul_valid_after", 64'(out_valid), 64'd1);
        drain();

        send(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 4'd6, 1'b1, 1'b1,
             mk(32'hFFFF_FFFE, 4'd6, 1'b1, 1'b0, 32'd0));
        drain();

        send(4'hC, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b1,
             mk(32'd14, 4'd7, 1'b1, 1'b0, 32'd0));
        send(4'hD, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0, 4'd8, 1'b1, 1'b1,
             mk(32'd2, 4'd8, 1'b1, 1'b0, 32'd0));
        send(4'hC, 32'h1234, 32'd0, 32'd0, 1'b0, 1'b0, 4'd9, 1'b1, 1'b1,
             mk(32'hFFFF_FFFF, 4'd9, 1'b1, 1'b0, 32'd0));
        send(4'hD, 32'h1234, 32'd0, 32'd0, 1'b0, 1'b0, 4'd10, 1'b1, 1'b1,
             mk(32'h1234, 4'd10, 1'b1, 1'b0, 32'd0));
        drain();

        out_ready = 1'b0;
        send(4'h0, 32'd1, 32'd0, 32'd1, 1'b1, 1'b0, 4'd1, 1'b1, 1'b1,
             mk(32'd2, 4'd1, 1'b1, 1'b0, 32'd0));
        in_rs1 = 32'd2; in_imm = 32'd2; in_rd = 4'd2; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ready_low", 64'(in_ready), 64'd0);
            chk("bp_hold", {out_valid, out_rd, out_result}, {1'b1, 4'd1, 32'd2});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        c0 = cyc;
        send(4'h0, 32'd2, 32'd0, 32'd2, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1,
             mk(32'd4, 4'd2, 1'b1, 1'b0, 32'd0));
        send(4'h0, 32'd3, 32'd0, 32'd3, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1,
             mk(32'd6, 4'd3, 1'b1, 1'b0, 32'd0));
        send(4'h0, 32'd4, 32'd0, 32'd4, 1'b1, 1'b0, 4'd4, 1'b1, 1'b1,
             mk(32'd8, 4'd4, 1'b1, 1'b0, 32'd0));
        chk("bp_throughput", 64'(cyc - c0), 64'd3);
        drain();

        send(4'hC, 32'd1000, 32'd3, 32'd0, 1'b0, 1'b0, 4'd11, 1'b1, 1'b0,
             mk(32'd0, 4'd0, 1'b0, 1'b0, 32'd0));
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("flush_busy_before", 64'(busy), 64'd1);
        chk("flush_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy_clr", 64'(busy), 64'd0);
        chk("flush_ready_up", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_result", 64'(seen), 64'd0);
        @(posedge clk);
        #1;

        send(4'hA, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0, 4'd12, 1'b1, 1'b0,
             mk(32'd0, 4'd0, 1'b0, 1'b0, 32'd0));
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_result", 64'(out_result), 64'd0);
        chk("rst_mid_sd", 64'(out_store_data), 64'd0);
        chk("rst_mid_ctrl",
            64'({out_valid, busy, out_rd, out_reg_write, out_mem_read,
                 out_mem_write, out_branch_taken}), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("rst_no_result", 64'(seen), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        in_pc = 32'h100;
        send(4'h4, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1,
             mk(32'd0, 4'd0, 1'b0, 1'b1, 32'h120));
        send(4'h6, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1,
             mk(32'h7FFF_FFFF, 4'd0, 1'b0, 1'b0, 32'd0));
        send(4'h2, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1,
             mk(32'hFFFF_FFFE, 4'd0, 1'b0, 1'b0, 32'd0));
        drain();

        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/exec_stage_mdu.md
Name: exec_stage_mdu

Overview:
- Parametrised next-generation execute stage for the SimpleARM core. It sits between decode and the memory/writeback stages.
- Adds valid/ready handshakes on both sides, a registered result bundle, flush support, and an iterative multiply/divide unit: MUL, MULHU, DIVU and REMU, each taking XLEN cycles.
- Load data is no longer muxed here. For a load, out_result carries the effective address to the memory stage.

Parameters:
- XLEN, 32, datapath width; must be a power of two, 8 or greater.
- REG_ADDR_W, 4, destination register address width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  decode presents an operation
- in_ready  out  1  stage can accept an operation this cycle
- in_pc  in  XLEN  program counter of the operation
- in_alu_op  in  4  operation code
- in_rs1  in  XLEN  source operand A
- in_rs2  in  XLEN  source operand B / store data
- in_imm  in  XLEN  immediate
- in_use_imm  in  1  operand B = in_imm
- in_mem_read  in  1  load
- in_mem_write  in  1  store
- in_branch  in  1  conditional branch
- in_reg_write  in  1  writes rd
- in_rd  in  REG_ADDR_W  destination register
- out_valid  out  1  result bundle valid
- out_ready  in  1  downstream accepts the bundle
- out_result  out  XLEN  ALU/MDU result, or memory address
- out_store_data  out  XLEN  registered in_rs2
- out_rd  out  REG_ADDR_W  registered in_rd
- out_reg_write  out  1  registered in_reg_write
- out_mem_read  out  1  registered in_mem_read
- out_mem_write  out  1  registered in_mem_write
- out_branch_taken  out  1  branch resolved taken
- out_branch_target  out  XLEN  in_pc+in_imm if taken, else 0
- busy  out  1  multi-cycle operation in progress

Behaviour:
- Reset (rst=1, async): state IDLE, all out_* = 0, busy=0, iteration counter 0. Reset mid-operation discards the operation; no result is emitted.
- Operand B = in_use_imm ? in_imm : in_rs2. Shift amount = B[log2(XLEN)-1:0].
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT (signed), 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND.
  - 1010 MUL: low XLEN bits of the product.
  - 1011 MULHU: high XLEN bits of the unsigned 2*XLEN product.
  - 1100 DIVU, 1101 REMU.
  - 1110/1111: result 0.
- Branch (in_branch=1), condition on in_alu_op[2:0]:
  - 000 EQ, 001 NE, 100 LT, 101 GE (signed), 110 LTU, 111 GEU; compares rs1 vs rs2.
  - 010/011: not taken.
  - Taken: target = in_pc+in_imm (mod 2^XLEN). Not taken: target = 0.
  - out_result = ALU result of in_alu_op, unused downstream.
- Multi-cycle class: in_alu_op in {1010..1101} with in_branch=0, in_mem_read=0, in_mem_write=0. Everything else is single-cycle.
- in_ready = (state==IDLE) && !flush && (!out_valid || out_ready). Acceptance = in_valid && in_ready.
- Single-cycle op accepted at edge T0: the bundle loads at T0 and out_valid=1 after T0.
- Multi-cycle op accepted at edge T0:
  - Operands and control fields are captured; state goes to BUSY with counter=XLEN; busy=1.
  - One radix-2 step per edge: shift-add for multiply, restoring shift-subtract for divide.
  - The edge where the counter reaches 0 loads the bundle, sets out_valid=1 and returns to IDLE.
  - out_valid is therefore high after edge T0+XLEN. in_ready and busy are high/low accordingly for XLEN cycles.
- Division by zero: DIVU returns all-ones; REMU returns the dividend. No exception is raised.
- Output hold: while out_valid && !out_ready, every out_* field stays stable.
- Drain: out_valid && out_ready with no new load clears out_valid at the next edge. A simultaneous drain and load keeps out_valid=1 with the new bundle (back-to-back throughput of 1 op/cycle for single-cycle ops).
- An op accepted while out is draining never overwrites an undrained bundle. The BUSY-exit load always finds the output empty, because acceptance required it.
- Flush (sync, priority below rst):
  - Clears out_valid; other out_* fields may keep stale values.
  - Aborts BUSY to IDLE, sets busy=0 and the counter to 0.
  - Blocks acceptance that cycle.
  - in_ready may rise the next cycle.

Test Plan:
- ADD: rs1=5, imm=7, use_imm=1, rd=3, reg_write=1 -> out_valid the cycle after accept, out_result=12, out_rd=3, out_reg_write=1.
- MUL / MULHU: rs1=rs2=0xFFFFFFFF.
  - MUL -> out_result=0x00000001; MULHU -> out_result=0xFFFFFFFE.
  - busy=1 and in_ready=0 for exactly 32 cycles; out_valid after edge T0+32.
- DIVU / REMU:
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
  - DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234.
- Backpressure: four back-to-back ADDs with out_ready=0 for 5 cycles after the first result.
  - in_ready=0 and the bundle is stable throughout.
  - When out_ready rises, ops drain one per cycle in order with no loss or duplication.
- Flush / reset abort:
  - flush asserted 10 cycles into a DIVU -> no result emitted, busy=0, in_ready=1 on the following cycle.
  - rst pulsed mid-MUL -> all outputs 0 immediately.
- Branch: pc=0x100, imm=0x20, rs1=0xFFFFFFFF, rs2=1.
  - BLT -> taken, target 0x120.
  - BLTU -> not taken, target 0.
  - Op 010 -> not taken.
